aes_decrypt_core: RTL and testbench



---
 rtl/aes_pkg.sv | 23 ++
 rtl/aes_inv_round.sv | 18 +
 rtl/aes_decrypt_core.sv | 88 ++++++++
 tb/tb_aes_decrypt_core.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
`default_nettype none
// ------------------------------------------------------------------
// aes_pkg: widths, FSM encodings and helpers shared by the AES cores
// Rev 1.0
// ------------------------------------------------------------------
package aes_pkg;

  localparam int DATA_W             = 128;
  localparam int AES_ROUNDS_DEFAULT = 10;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_INIT   = 2'd1;
  localparam logic [1:0] ST_ROUNDS = 2'd2;
  localparam logic [1:0] ST_DONE   = 2'd3;

  // Bits needed to hold round counts 0..rounds-1, never less than one.
  function automatic int ctr_width(input int rounds);
    if (rounds <= 2) return 1;
    return $clog2(rounds);
  endfunction

endpackage
`default_nettype wire

// File: rtl/aes_inv_round.sv
`default_nettype none
// ------------------------------------------------------------------
// aes_inv_round: one combinational inverse round (AddRoundKey only)
// Rev 1.0
// ------------------------------------------------------------------
module aes_inv_round
  import aes_pkg::*;
(
  input  logic [DATA_W-1:0] state,
  input  logic [DATA_W-1:0] round_key,
  output logic [DATA_W-1:0] next_state
);

  // InvShiftRows / InvSubBytes / InvMixColumns slot in ahead of this XOR.
  assign next_state = state ^ round_key;

endmodule
`default_nettype wire

// File: rtl/aes_decrypt_core.sv
`default_nettype none
// ------------------------------------------------------------------
// aes_decrypt_core: iterative decryptor, one round per clock, zeroizes
// key and state whenever an operation completes or is aborted. Rev 1.0
// ------------------------------------------------------------------
module aes_decrypt_core
  import aes_pkg::*;
#(
  parameter int AES_ROUNDS = AES_ROUNDS_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] key,
  input  logic [DATA_W-1:0] ciphertext,
  input  logic              start,
  input  logic              abort,
  output logic [DATA_W-1:0] plaintext,
  output logic              plaintext_valid,
  output logic              busy,
  output logic              done
);

  localparam int CTR_W = ctr_width(AES_ROUNDS);

  logic [1:0]        fsm;
  logic [DATA_W-1:0] state_reg;
  logic [DATA_W-1:0] key_reg;
  logic [DATA_W-1:0] round_out;
  logic [CTR_W-1:0]  round_ctr;

  aes_inv_round u_inv_round (
    .state      (state_reg),
    .round_key  (key_reg),
    .next_state (round_out)
  );

  assign busy = (fsm != ST_IDLE);

  always_ff @(posedge clk) begin
    // abort behaves as a reset of the datapath so no secret survives it
    if (rst || abort) begin
      fsm             <= ST_IDLE;
      state_reg       <= '0;
      key_reg         <= '0;
      round_ctr       <= '0;
      plaintext       <= '0;
      plaintext_valid <= 1'b0;
      done            <= 1'b0;
    end else begin
      done <= 1'b0;
      case (fsm)
        ST_IDLE: begin
          if (start) begin
            state_reg       <= ciphertext;
            key_reg         <= key;
            round_ctr       <= CTR_W'(AES_ROUNDS - 1);
            plaintext       <= '0;
            plaintext_valid <= 1'b0;
            fsm             <= ST_INIT;
          end
        end
        ST_INIT: begin
          state_reg <= round_out;
          fsm       <= ST_ROUNDS;
        end
        ST_ROUNDS: begin
          state_reg <= round_out;
          if (round_ctr == '0) begin
            fsm <= ST_DONE;
          end else begin
            round_ctr <= round_ctr - CTR_W'(1);
          end
        end
        ST_DONE: begin
          plaintext       <= state_reg;
          plaintext_valid <= 1'b1;
          done            <= 1'b1;
          state_reg       <= '0;
          key_reg         <= '0;
          round_ctr       <= '0;
          fsm             <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_aes_decrypt_core.sv
`default_nettype none
// ------------------------------------------------------------------
// tb_aes_decrypt_core: randomized scoreboard bench for aes_decrypt_core
// Rev 1.0
// ------------------------------------------------------------------
module tb_aes_decrypt_core;

  localparam int R = 10;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [127:0] key = '0;
  logic [127:0] ciphertext = '0;
  logic         start = 1'b0;
  logic         abort = 1'b0;
  logic [127:0] plaintext;
  logic         plaintext_valid;
  logic         busy;
  logic         done;

  aes_decrypt_core #(.AES_ROUNDS(R)) dut (
    .clk             (clk),
    .rst             (rst),
    .key             (key),
    .ciphertext      (ciphertext),
    .start           (start),
    .abort           (abort),
    .plaintext       (plaintext),
    .plaintext_valid (plaintext_valid),
    .busy            (busy),
    .done            (done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [127:0] pt;
    int           due;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_bad = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Each cipher applies the round (state XOR key) AES_ROUNDS+1 times.
  function automatic logic [127:0] apply_rounds(input logic [127:0] blk, input logic [127:0] k);
    logic [127:0] s = blk;
    for (int i = 0; i <= R; i++) s = s ^ k;
    return s;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (done) begin
      if (sb.size() == 0) begin
        check("unexpected_done", 128'(done), 128'(0));
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("plaintext", plaintext, e.pt);
        check("done_cycle", 128'(cyc), 128'(e.due));
        check("valid_on_done", 128'(plaintext_valid), 128'(1));
        check("busy_on_done", 128'(busy), 128'(0));
      end
    end else if (sb.size() > 0 && cyc > sb[0].due) begin
      check("done_timeout", 128'(done), 128'(1));
      void'(sb.pop_front());
    end
  end

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (busy) check("idle_timeout", 128'(busy), 128'(0));
  endtask

  task automatic wait_done();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!done && n < 100);
    if (!done) check("wait_done_timeout", 128'(done), 128'(1));
  endtask

  // Issue one start; an expectation is queued only when a result is wanted.
  task automatic issue(input logic [127:0] k, input logic [127:0] c,
                       input logic [127:0] exp_pt, input bit want);
    wait_idle();
    key        = k;
    ciphertext = c;
    start      = 1'b1;
    if (want) sb.push_back('{exp_pt, cyc + 1 + R + 2});
    @(negedge clk);
    start = 1'b0;
  endtask

  initial begin
    logic [127:0] k, c, p, basic_pt;

    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("reset_plaintext", plaintext, '0);
    check("reset_valid", 128'(plaintext_valid), 128'(0));
    check("reset_busy", 128'(busy), 128'(0));
    check("reset_done", 128'(done), 128'(0));

    // Basic decrypt and zeroization on the done cycle
    basic_pt = 128'h00102030405060708090a0b0c0d0e0f0;
    issue(128'h000102030405060708090a0b0c0d0e0f, 128'h00112233445566778899aabbccddeeff,
          basic_pt, 1'b1);
    check("busy_after_start", 128'(busy), 128'(1));
    wait_done();
    check("zero_key_on_done", dut.key_reg, '0);
    check("zero_state_on_done", dut.state_reg, '0);
    repeat (3) @(negedge clk);
    check("valid_holds", 128'(plaintext_valid), 128'(1));
    check("plaintext_holds", plaintext, basic_pt);

    // Round trip against the paired encryptor's transform
    p = 128'h0123456789abcdeffedcba9876543210;
    k = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    c = apply_rounds(p, k);
    issue(k, c, p, 1'b1);
    check("plaintext_cleared_on_start", plaintext, '0);
    check("valid_cleared_on_start", 128'(plaintext_valid), 128'(0));
    wait_idle();

    // start held high with inputs changing mid-operation
    k = rand128();
    c = rand128();
    key = k;
    ciphertext = c;
    start = 1'b1;
    sb.push_back('{apply_rounds(c, k), cyc + 1 + R + 2});
    repeat (4) @(negedge clk);
    k = rand128();
    c = rand128();
    key = k;
    ciphertext = c;
    wait_done();
    sb.push_back('{apply_rounds(c, k), cyc + 1 + R + 2});
    @(negedge clk);
    start = 1'b0;
    wait_idle();
    @(negedge clk);

    // abort in ROUNDS
    issue(rand128(), rand128(), '0, 1'b0);
    repeat (3) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_busy", 128'(busy), 128'(0));
    check("abort_key_reg", dut.key_reg, '0);
    check("abort_state_reg", dut.state_reg, '0);
    check("abort_valid", 128'(plaintext_valid), 128'(0));
    repeat (15) @(negedge clk);

    // rst mid-ROUNDS
    issue(rand128(), rand128(), '0, 1'b0);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst_busy", 128'(busy), 128'(0));
    check("rst_fsm", 128'(dut.fsm), 128'(0));
    check("rst_key_reg", dut.key_reg, '0);
    check("rst_plaintext", plaintext, '0);
    repeat (15) @(negedge clk);

    // abort + start together in IDLE after a completed operation
    k = rand128();
    c = rand128();
    issue(k, c, apply_rounds(c, k), 1'b1);
    wait_done();
    @(negedge clk);
    check("valid_before_abort", 128'(plaintext_valid), 128'(1));
    key = rand128();
    ciphertext = rand128();
    start = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    check("idle_abort_valid", 128'(plaintext_valid), 128'(0));
    check("idle_abort_plaintext", plaintext, '0);
    check("idle_abort_busy", 128'(busy), 128'(0));
    check("idle_abort_key_reg", dut.key_reg, '0);
    repeat (15) @(negedge clk);

    // Randomized traffic, including back-to-back starts
    for (int i = 0; i < 16; i++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      k = rand128();
      c = rand128();
      issue(k, c, apply_rounds(c, k), 1'b1);
    end

    begin
      int n = 0;
      while (sb.size() > 0 && n < 60) begin
        @(negedge clk);
        n++;
      end
    end
    if (sb.size() > 0) check("drain", 128'(sb.size()), 128'(0));
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule
`default_nettype wire
